// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and element indexing for the matrix result serializer.
package mat_pkg;

  localparam int MAT_ROWS  = 4;
  localparam int MAT_COLS  = 2;
  localparam int MAT_IN_W  = 12;
  localparam int MAT_OUT_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  // Row-major flat index of a result element.
  function automatic int elem_idx(input int row, input int col, input int cols = MAT_COLS);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/mat_result_serializer_sat_signed.sv
// Combinational signed clip from IN_W to OUT_W; zero latency, no flow control.
module sat_signed #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam logic [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MINV = ~MAXV;

  always_comb begin
    sat = 1'b0;
    y   = x[OUT_W-1:0];
    if ($signed(x) > $signed(MAXV)) begin
      sat = 1'b1;
      y   = MAXV[OUT_W-1:0];
    end else if ($signed(x) < $signed(MINV)) begin
      sat = 1'b1;
      y   = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mat_result_serializer.sv
// Captures a ROWSxCOLS result matrix in one handshake and streams it row-major, saturated, one beat per cycle.
// First beat one cycle after capture; outputs hold under m_ready stall, capture is refused until the frame ends.
module mat_result_serializer
  import mat_pkg::*;
#(
  parameter int ROWS  = MAT_ROWS,
  parameter int COLS  = MAT_COLS,
  parameter int IN_W  = MAT_IN_W,
  parameter int OUT_W = MAT_OUT_W,
  parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cap_valid,
  output logic                      cap_ready,
  input  logic [ROWS*COLS*IN_W-1:0] s_flat,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_W-1:0]          m_data,
  output logic [RW-1:0]             m_row,
  output logic [CW-1:0]             m_col,
  output logic                      m_last,
  output logic                      m_sat,
  output logic                      done
);

  localparam int N    = ROWS * COLS;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int LAST = elem_idx(ROWS - 1, COLS - 1, COLS);

  state_t              state;
  logic [KW-1:0]       k;
  logic [N*IN_W-1:0]   bank;
  logic [KW-1:0]       sel_idx;
  logic [IN_W-1:0]     sel_elem;
  logic [OUT_W-1:0]    sat_val;
  logic                sat_flag;
  logic [RW-1:0]       sel_row;
  logic [CW-1:0]       sel_col;
  logic                sel_last;

  // The element that will be on the outputs after the next load: element 0 of
  // the incoming bus when capturing, otherwise the successor of k in the bank.
  always_comb begin
    sel_idx  = (state == SEND) ? k + KW'(1) : '0;
    sel_elem = (state == SEND) ? bank[sel_idx*IN_W +: IN_W] : s_flat[IN_W-1:0];
    sel_row  = RW'(int'(sel_idx) / COLS);
    sel_col  = CW'(int'(sel_idx) % COLS);
    sel_last = (int'(sel_idx) == LAST);
  end

  sat_signed #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .x   (sel_elem),
    .y   (sat_val),
    .sat (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      bank      <= '0;
      cap_ready <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_row     <= '0;
      m_col     <= '0;
      m_last    <= 1'b0;
      m_sat     <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cap_valid) begin
            bank      <= s_flat;
            k         <= '0;
            cap_ready <= 1'b0;
            m_valid   <= 1'b1;
            m_data    <= sat_val;
            m_sat     <= sat_flag;
            m_row     <= sel_row;
            m_col     <= sel_col;
            m_last    <= sel_last;
            state     <= SEND;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (int'(k) == LAST) begin
              m_valid <= 1'b0;
              m_data  <= '0;
              m_row   <= '0;
              m_col   <= '0;
              m_last  <= 1'b0;
              m_sat   <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              k      <= sel_idx;
              m_data <= sat_val;
              m_sat  <= sat_flag;
              m_row  <= sel_row;
              m_col  <= sel_col;
              m_last <= sel_last;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          cap_ready <= 1'b1;
          k         <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Randomized and directed stimulus against a queue-based reference of the expected beat stream.
module tb_mat_result_serializer;

  localparam int ROWS = 4, COLS = 2, IN_W = 12, OUT_W = 8, N = ROWS * COLS;

  logic              clk, rst_n, cap_valid, cap_ready, m_valid, m_ready;
  logic              m_last, m_sat, done;
  logic [N*IN_W-1:0] s_flat;
  logic [OUT_W-1:0]  m_data;
  logic [1:0]        m_row;
  logic [0:0]        m_col;

  mat_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .s_flat(s_flat), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last), .m_sat(m_sat), .done(done)
  );

  typedef struct {
    int data;
    int sat;
    int row;
    int col;
    int last;
  } beat_t;

  int    checks = 0, failures = 0;
  int    s_mat[N];
  beat_t q[$];
  beat_t obs[$];
  bit    done_exp = 0;
  bit    cap_taken = 0;
  int    rmode = 0;
  int    rcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected beat from the saturation rule and row-major ordering.
  function automatic beat_t model_beat(input int x, input int idx);
    beat_t b;
    b.sat = 0;
    b.data = x;
    if (x > 127) begin b.data = 127; b.sat = 1; end
    else if (x < -128) begin b.data = -128; b.sat = 1; end
    b.row  = idx / COLS;
    b.col  = idx % COLS;
    b.last = (idx == N - 1) ? 1 : 0;
    return b;
  endfunction

  task automatic set_mat(input int vals[N]);
    for (int i = 0; i < N; i++) begin
      s_mat[i] = vals[i];
      s_flat[i*IN_W +: IN_W] = vals[i][IN_W-1:0];
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ((rcnt % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: DUT against the expected stream, and advance the model.
  always @(negedge clk) begin
    bit    exp_valid;
    bit    next_done;
    beat_t b;
    if (rst_n) begin
      exp_valid = (q.size() > 0);
      chk("m_valid", int'(m_valid), int'(exp_valid));
      chk("done", int'(done), int'(done_exp));
      chk("cap_ready", int'(cap_ready), int'(!exp_valid && !done_exp));
      if (exp_valid && m_valid) begin
        chk("m_data", int'($signed(m_data)), q[0].data);
        chk("m_sat", int'(m_sat), q[0].sat);
        chk("m_row", int'(m_row), q[0].row);
        chk("m_col", int'(m_col), q[0].col);
        chk("m_last", int'(m_last), q[0].last);
      end
      next_done = 0;
      if (exp_valid && m_ready) begin
        b.data = int'($signed(m_data));
        b.sat = int'(m_sat); b.row = int'(m_row); b.col = int'(m_col); b.last = int'(m_last);
        obs.push_back(b);
        if (q[0].last != 0) next_done = 1;
        void'(q.pop_front());
      end
      if (cap_valid && !exp_valid && !done_exp) begin
        for (int i = 0; i < N; i++) q.push_back(model_beat(s_mat[i], i));
        cap_taken = 1;
      end
      done_exp = next_done;
    end
  end

  task automatic wait_capture();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (cap_taken) begin ok = 1; break; end
    end
    if (!ok) chk("capture_timeout", 0, 1);
    cap_taken = 0;
    cap_valid = 1'b0;
  endtask

  task automatic run_frame(input int vals[N]);
    set_mat(vals);
    cap_valid = 1'b1;
    wait_capture();
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !done_exp) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input int off, input int d[N], input int s[N]);
    if (obs.size() < off + N) begin
      chk({name, "_count"}, obs.size(), off + N);
    end else begin
      for (int i = 0; i < N; i++) begin
        chk({name, "_data"}, obs[off+i].data, d[i]);
        chk({name, "_sat"}, obs[off+i].sat, s[i]);
      end
    end
  endtask

  initial begin
    int rv[N];
    rst_n = 1'b0; cap_valid = 1'b0; m_ready = 1'b0; s_flat = '0;
    for (int i = 0; i < N; i++) s_mat[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_ready", int'(cap_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_tags", int'({m_row, m_col, m_last, m_sat}), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // In-range stream at full rate.
    rmode = 0;
    obs.delete();
    run_frame('{4, 12, 19, 23, 27, 28, -3, 24});
    wait_idle();
    check_obs("inrange", 0, '{4, 12, 19, 23, 27, 28, -3, 24}, '{0, 0, 0, 0, 0, 0, 0, 0});
    if (obs.size() >= N) chk("inrange_last", obs[N-1].last, 1);

    // Saturation boundaries.
    obs.delete();
    run_frame('{300, -300, 127, -128, 128, -129, 0, -1});
    wait_idle();
    check_obs("sat", 0, '{127, -128, 127, -128, 127, -128, 0, -1}, '{1, 1, 0, 0, 1, 1, 0, 0});

    // Backpressure 1,0,0 pattern.
    rmode = 1;
    obs.delete();
    run_frame('{-2048, 2047, 5, -5, 100, -100, 129, -130});
    wait_idle();
    check_obs("bp", 0, '{-128, 127, 5, -5, 100, -100, 127, -128}, '{1, 1, 0, 0, 0, 0, 1, 1});

    // Capture requested mid-stream must wait for the frame to end.
    rmode = 0;
    obs.delete();
    run_frame('{10, 20, 30, 40, 50, 60, 70, 80});
    set_mat('{1, 2, 3, 4, 5, 6, 7, 8});
    cap_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("blocked_cap_ready", int'(cap_ready), 0);
    wait_capture();
    wait_idle();
    check_obs("blk_a", 0, '{10, 20, 30, 40, 50, 60, 70, 80}, '{0, 0, 0, 0, 0, 0, 0, 0});
    check_obs("blk_b", N, '{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Reset mid-stream aborts the frame with no done pulse.
    obs.delete();
    run_frame('{9, 8, 7, 6, 5, 4, 3, 2});
    for (int i = 0; i < 50 && obs.size() < 3; i++) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    q.delete();
    done_exp = 0;
    cap_taken = 0;
    #1;
    chk("abort_m_valid", int'(m_valid), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    obs.delete();
    run_frame('{-7, 6, -5, 4, -3, 2, -1, 0});
    wait_idle();
    check_obs("after_rst", 0, '{-7, 6, -5, 4, -3, 2, -1, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    if (obs.size() > 0) chk("after_rst_row0", obs[0].row + obs[0].col, 0);

    // Randomized frames, back-to-back or spaced, random ready.
    rmode = 2;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) != 0) rv[i] = int'($urandom_range(0, 4095)) - 2048;
        else rv[i] = int'($urandom_range(0, 300)) - 150;
      end
      run_frame(rv);
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
